// File: rtl/i2s_clkgen.sv
// ---------------------------------------------------------------------------
// i2s_clkgen -- I2S bit/frame clock generator
//
// Produces the I2S bit clock (64 bit slots per frame, 50% duty), the
// left/right select, a per-frame start strobe and the current bit slot.
// All outputs are registered on clk_i. The bit clock half period is H clk_i
// cycles, where H is hdiv_i latched at each frame start (a value of 0 is
// treated as 1), so one frame is 128*H clk_i cycles.
//
// Parameters
//   HDIV_W    width of hdiv_i (default 8)
//   MCLK_DIV  clk_i cycles per mclk_o half period (only with the macro below)
//
// Ports
//   clk_i        in   system clock, rising edge
//   rst_i        in   synchronous reset, active high
//   en_i         in   run request (level); sampled at frame boundaries
//   hdiv_i       in   clk_i cycles per bclk half period, latched at frame start
//   bclk_o       out  bit clock
//   lrclk_o      out  0 = left half-frame, 1 = right half-frame
//   sampstart_o  out  one-cycle strobe at the start of each frame
//   bitcnt_o     out  current bit slot 0..63
//   running_o    out  1 while frames are being generated
//   mclk_o       out  free-running master clock (only with the macro below)
//
// Build option
//   I2S_CLKGEN_MCLK_EN  when defined, adds mclk_o and its divider; mclk_o
//                       toggles every MCLK_DIV clk_i cycles from reset
//                       release regardless of en_i or the run state.
// ---------------------------------------------------------------------------
module i2s_clkgen #(
  parameter int HDIV_W   = 8,
  parameter int MCLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [HDIV_W-1:0] hdiv_i,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic              sampstart_o,
  output logic [5:0]        bitcnt_o,
  output logic              running_o
`ifdef I2S_CLKGEN_MCLK_EN
  ,
  output logic              mclk_o
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [HDIV_W-1:0] H_ONE = HDIV_W'(1);

  state_t            state_reg, state_next;
  logic [HDIV_W-1:0] h_reg,     h_next;      // latched half period
  logic [HDIV_W-1:0] half_reg,  half_next;   // position within the half period
  logic              bclk_reg,  bclk_next;
  logic [5:0]        bit_reg,   bit_next;
  logic              samp_reg,  samp_next;

  logic [HDIV_W-1:0] h_sampled;
  logic              half_wrap;

  // A zero divider would never let the half counter wrap; treat it as 1.
  assign h_sampled = (hdiv_i == '0) ? H_ONE : hdiv_i;
  assign half_wrap = (half_reg == (h_reg - H_ONE));

  // -------------------------------------------------------------------------
  // Next-state / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    half_next  = half_reg;
    bclk_next  = bclk_reg;
    bit_next   = bit_reg;
    samp_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        half_next = '0;
        bclk_next = 1'b0;
        bit_next  = 6'd0;
        if (en_i) begin
          // The start edge behaves exactly like a frame wrap: counters at
          // zero, strobe in the following cycle, first bclk rise H cycles on.
          state_next = ST_RUN;
          h_next     = h_sampled;
          samp_next  = 1'b1;
        end
      end

      ST_RUN: begin
        if (half_wrap) begin
          half_next = '0;
          bclk_next = ~bclk_reg;
          if (bclk_reg) begin
            // Falling bclk edge: advance the slot in the same cycle so that
            // lrclk (bit 5 of the slot) only ever moves with a falling edge.
            bit_next = bit_reg + 6'd1;
            if (bit_reg == 6'd63) begin
              // Frame boundary: en_i decides between a new frame and IDLE.
              if (en_i) begin
                samp_next = 1'b1;
                h_next    = h_sampled;
              end else begin
                state_next = ST_IDLE;
              end
            end
          end
        end else begin
          half_next = half_reg + H_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        half_next  = '0;
        bclk_next  = 1'b0;
        bit_next   = 6'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      h_reg     <= H_ONE;
      half_reg  <= '0;
      bclk_reg  <= 1'b0;
      bit_reg   <= 6'd0;
      samp_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      h_reg     <= h_next;
      half_reg  <= half_next;
      bclk_reg  <= bclk_next;
      bit_reg   <= bit_next;
      samp_reg  <= samp_next;
    end
  end

  assign bclk_o      = bclk_reg;
  assign bitcnt_o    = bit_reg;
  assign lrclk_o     = bit_reg[5];
  assign sampstart_o = samp_reg;
  assign running_o   = (state_reg == ST_RUN);

`ifdef I2S_CLKGEN_MCLK_EN
  // -------------------------------------------------------------------------
  // Free-running master clock divider, independent of the frame logic.
  // -------------------------------------------------------------------------
  localparam int               MCW       = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam logic [MCW-1:0]   MCLK_LAST = MCW'(MCLK_DIV - 1);

  logic [MCW-1:0] mclk_cnt_reg, mclk_cnt_next;
  logic           mclk_reg,     mclk_next;

  always_comb begin
    mclk_cnt_next = mclk_cnt_reg + MCW'(1);
    mclk_next     = mclk_reg;
    if (mclk_cnt_reg == MCLK_LAST) begin
      mclk_cnt_next = '0;
      mclk_next     = ~mclk_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mclk_cnt_reg <= '0;
      mclk_reg     <= 1'b0;
    end else begin
      mclk_cnt_reg <= mclk_cnt_next;
      mclk_reg     <= mclk_next;
    end
  end

  assign mclk_o = mclk_reg;
`endif

endmodule
